i2s_audio_tx: RTL and testbench

I2S stereo serializer clocked by the 24.576 MHz audio output of the system PLL. It derives BCLK and LRCLK from that clock and accepts 16-bit stereo samples over a valid/ready port. It shifts the samples out in Philips I2S format: 64 BCLK per frame, 48 kHz frame rate with default parameters. It stays idle until the PLL reports lock.

---
 rtl/audio_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/i2s_audio_tx.sv | 231 +++++++++++++++++++++++
 tb/tb_i2s_audio_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample geometry, frame length and the
// stereo sample pair type used by the audio transmit path.
package audio_pkg;

    localparam int SAMPLE_WIDTH_DEF = 16;
    localparam int SLOT_WIDTH_DEF   = 32;
    localparam int BCLK_DIV_DEF     = 8;

    // clk cycles per stereo frame: two slots of SLOT_WIDTH bit clocks each
    localparam int FRAME_CLKS = 2 * SLOT_WIDTH_DEF * BCLK_DIV_DEF;

    typedef struct packed {
        logic [SAMPLE_WIDTH_DEF-1:0] left;
        logic [SAMPLE_WIDTH_DEF-1:0] right;
    } stereo_sample_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // capture the asynchronous level through two flops, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/i2s_audio_tx.sv
// Philips I2S stereo serializer. Derives BCLK/LRCLK from the audio clock,
// buffers one stereo pair and shifts it out MSB-first with the one-BCLK
// I2S data delay. All outputs are registered; the datapath is computed as
// next-state values so that registered outputs line up with the counters.
module i2s_audio_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int SLOT_WIDTH   = SLOT_WIDTH_DEF,
    parameter int BCLK_DIV     = BCLK_DIV_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic [SAMPLE_WIDTH-1:0] in_left,
    input  logic [SAMPLE_WIDTH-1:0] in_right,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    i2s_bclk,
    output logic                    i2s_lrclk,
    output logic                    i2s_sdata,
    output logic                    underflow
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_WIDTH);

    localparam logic [FRAME_BITS-1:0]   FRAME_ZERO  = {FRAME_BITS{1'b0}};
    localparam logic [SAMPLE_WIDTH-1:0] SAMPLE_ZERO = {SAMPLE_WIDTH{1'b0}};

    // Frame image: each channel left-justified in its slot, zero padded.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [SAMPLE_WIDTH-1:0] left,
        input logic [SAMPLE_WIDTH-1:0] right
    );
        logic [FRAME_BITS-1:0] f;
        f = {FRAME_BITS{1'b0}};
        f[FRAME_BITS-1 -: SAMPLE_WIDTH] = left;
        f[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = right;
        return f;
    endfunction

    // synchronized lock
    logic lock_s;

    // state registers
    tx_state_e               state_r;
    logic [DIV_W-1:0]        div_cnt_r;
    logic [BIT_W-1:0]        bit_cnt_r;
    logic [FRAME_BITS-1:0]   shift_r;
    logic                    full_r;
    logic [SAMPLE_WIDTH-1:0] hold_left_r;
    logic [SAMPLE_WIDTH-1:0] hold_right_r;
    logic                    bclk_r;
    logic                    lrclk_r;
    logic                    ready_r;
    logic                    underflow_r;

    // next-state values
    tx_state_e               state_nxt_s;
    logic                    run_s;
    logic                    run_nxt_s;
    logic                    fe_s;
    logic                    load_s;
    logic                    xfer_s;
    logic [DIV_W-1:0]        div_nxt_s;
    logic [BIT_W-1:0]        bit_nxt_s;
    logic [FRAME_BITS-1:0]   shift_nxt_s;
    logic                    full_nxt_s;
    logic [SAMPLE_WIDTH-1:0] hold_left_nxt_s;
    logic [SAMPLE_WIDTH-1:0] hold_right_nxt_s;
    logic                    underflow_nxt_s;
    logic                    bclk_nxt_s;
    logic                    lrclk_nxt_s;
    logic                    ready_nxt_s;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // FSM transitions: run only while the synchronized lock is present
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (lock_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (lock_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Frame events: fe closes a BCLK period, load is the fe that starts a frame
    always_comb begin
        run_s     = (state_r == ST_RUN);
        run_nxt_s = (state_nxt_s == ST_RUN);
        fe_s      = run_s && (div_cnt_r == DIV_LAST);
        load_s    = fe_s && (bit_cnt_r == BIT_ZERO);
        xfer_s    = in_valid && ready_r;
    end

    // Counters, holding register and shift register; cleared outside RUN
    always_comb begin
        div_nxt_s        = DIV_ZERO;
        bit_nxt_s        = BIT_ZERO;
        shift_nxt_s      = FRAME_ZERO;
        full_nxt_s       = 1'b0;
        hold_left_nxt_s  = SAMPLE_ZERO;
        hold_right_nxt_s = SAMPLE_ZERO;
        underflow_nxt_s  = 1'b0;
        if (run_s && run_nxt_s) begin
            if (fe_s) begin
                div_nxt_s = DIV_ZERO;
            end else begin
                div_nxt_s = div_cnt_r + DIV_ONE;
            end

            if (fe_s) begin
                if (bit_cnt_r == BIT_LAST) begin
                    bit_nxt_s = BIT_ZERO;
                end else begin
                    bit_nxt_s = bit_cnt_r + BIT_ONE;
                end
            end else begin
                bit_nxt_s = bit_cnt_r;
            end

            // An empty holding register at load sends a silent frame.
            if (load_s) begin
                if (full_r) begin
                    shift_nxt_s = build_frame(hold_left_r, hold_right_r);
                end else begin
                    shift_nxt_s = FRAME_ZERO;
                end
            end else if (fe_s) begin
                shift_nxt_s = {shift_r[FRAME_BITS-2:0], 1'b0};
            end else begin
                shift_nxt_s = shift_r;
            end

            // A transfer on the load cycle refills the register just drained.
            if (xfer_s) begin
                full_nxt_s       = 1'b1;
                hold_left_nxt_s  = in_left;
                hold_right_nxt_s = in_right;
            end else if (load_s) begin
                full_nxt_s       = 1'b0;
                hold_left_nxt_s  = hold_left_r;
                hold_right_nxt_s = hold_right_r;
            end else begin
                full_nxt_s       = full_r;
                hold_left_nxt_s  = hold_left_r;
                hold_right_nxt_s = hold_right_r;
            end

            underflow_nxt_s = load_s && !full_r;
        end else begin
            underflow_nxt_s = 1'b0;
        end
    end

    // Output values derived from next-state so they align with the counters
    always_comb begin
        bclk_nxt_s  = run_nxt_s && (div_nxt_s >= DIV_HALF);
        lrclk_nxt_s = run_nxt_s && (bit_nxt_s >= BIT_SLOT);
        ready_nxt_s = run_nxt_s &&
                      (!full_nxt_s ||
                       ((div_nxt_s == DIV_LAST) && (bit_nxt_s == BIT_ZERO)));
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            div_cnt_r    <= DIV_ZERO;
            bit_cnt_r    <= BIT_ZERO;
            shift_r      <= FRAME_ZERO;
            full_r       <= 1'b0;
            hold_left_r  <= SAMPLE_ZERO;
            hold_right_r <= SAMPLE_ZERO;
            bclk_r       <= 1'b0;
            lrclk_r      <= 1'b0;
            ready_r      <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            div_cnt_r    <= div_nxt_s;
            bit_cnt_r    <= bit_nxt_s;
            shift_r      <= shift_nxt_s;
            full_r       <= full_nxt_s;
            hold_left_r  <= hold_left_nxt_s;
            hold_right_r <= hold_right_nxt_s;
            bclk_r       <= bclk_nxt_s;
            lrclk_r      <= lrclk_nxt_s;
            ready_r      <= ready_nxt_s;
            underflow_r  <= underflow_nxt_s;
        end
    end

    assign in_ready  = ready_r;
    assign i2s_bclk  = bclk_r;
    assign i2s_lrclk = lrclk_r;
    assign i2s_sdata = shift_r[FRAME_BITS-1];
    assign underflow = underflow_r;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Scoreboard bench for i2s_audio_tx: the driver queues every accepted pair
// with its acceptance cycle; a monitor decodes the I2S wire and compares
// each frame against the oldest pair accepted before that frame's load.
module tb_i2s_audio_tx;
    import audio_pkg::*;

    localparam int SW    = 16;
    localparam int SLOT  = 32;
    localparam int DIV   = 8;
    localparam int FB    = 2 * SLOT;
    localparam int FRAME = FB * DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic [SW-1:0] in_left = '0;
    logic [SW-1:0] in_right = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, i2s_bclk, i2s_lrclk, i2s_sdata, underflow;

    i2s_audio_tx #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SLOT), .BCLK_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .in_left    (in_left),
        .in_right   (in_right),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrclk  (i2s_lrclk),
        .i2s_sdata  (i2s_sdata),
        .underflow  (underflow)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // scoreboard: pairs in acceptance order, stamped with the accepting posedge
    typedef struct { stereo_sample_t s; int acc; } exp_t;
    exp_t q[$];

    // monitor state (read by the driver only for pacing)
    int  pos = 0, low_cnt = 0, hi_cnt = 0, loads_seen = 0, last_load = -1;
    int  uf_seen = 0, uf_exp = 0;
    bit  frame_valid = 0, align_on = 0;
    logic prev_bclk = 0, prev_uf = 0, prev_sd = 0, prev_lr = 0;
    logic [FB-1:0] fbits = '0, lbits = '0;
    logic [FB-1:0] lr_exp = {{SLOT{1'b0}}, {SLOT{1'b1}}};
    stereo_sample_t exp_s = '0;

    initial begin : monitor
        bit fell, rose, exp_uf;
        exp_t e;
        forever begin
            @(negedge clk);
            fell = prev_bclk && !i2s_bclk;
            rose = !prev_bclk && i2s_bclk;
            if (underflow) begin
                uf_seen++;
                check("underflow_pulse_width", prev_uf, 1'b0);
            end
            if (align_on && ((i2s_sdata !== prev_sd) || (i2s_lrclk !== prev_lr)))
                check("data_changes_on_bclk_fall", fell, 1'b1);
            if (i2s_bclk) hi_cnt++;
            if (i2s_bclk) low_cnt = 0; else low_cnt++;
            if (low_cnt >= DIV) begin
                pos = 0; frame_valid = 0; last_load = -1;
            end
            if (fell) begin
                if (align_on) check("bclk_high_width", hi_cnt, DIV / 2);
                hi_cnt = 0;
                pos = (pos + 1) % FB;
                if (pos == 1) begin
                    loads_seen++;
                    if (last_load >= 0) check("frame_length", cyc - last_load, FRAME);
                    last_load = cyc;
                    if (q.size() > 0 && q[0].acc < cyc) begin
                        e = q.pop_front();
                        exp_s = e.s; exp_uf = 0;
                    end else begin
                        exp_s = '0; exp_uf = 1; uf_exp++;
                    end
                    check("underflow_at_load", underflow, exp_uf);
                    frame_valid = 1; fbits = '0; lbits = '0;
                end
            end
            if (rose) begin
                fbits[FB-1-pos] = i2s_sdata;
                lbits[FB-1-pos] = i2s_lrclk;
                if (pos == FB - 1 && frame_valid) begin
                    check("left_slot", fbits[FB-2 -: SW], exp_s.left);
                    check("right_slot", fbits[SLOT-2 -: SW], exp_s.right);
                    check("slot_padding", {fbits[FB-2-SW:SLOT-1], fbits[SLOT-2-SW:0]}, '0);
                    check("lrclk_pattern", lbits, lr_exp);
                    frame_valid = 0;
                end
            end
            prev_bclk = i2s_bclk; prev_uf = underflow;
            prev_sd = i2s_sdata; prev_lr = i2s_lrclk;
        end
    end

    task automatic push(input logic [SW-1:0] l, input logic [SW-1:0] r, input int acc);
        exp_t e;
        e.s.left = l; e.s.right = r; e.acc = acc;
        q.push_back(e);
    endtask

    task automatic send_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
        int k = 0;
        in_left = l; in_right = r; in_valid = 1'b1;
        while (!in_ready && k < 1200) begin @(negedge clk); k++; end
        check("send_accepted", in_ready, 1'b1);
        if (in_ready) push(l, r, cyc + 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int budget);
        int k = 0;
        while (!in_ready && k < budget) begin @(negedge clk); k++; end
        check(name, in_ready, 1'b1);
    endtask

    task automatic wait_loads(input string name, input int target);
        int k = 0;
        while (loads_seen < target && k < 3 * FRAME) begin @(negedge clk); k++; end
        @(negedge clk);
        check(name, loads_seen >= target, 1'b1);
    endtask

    // back-pressure: valid held high, incrementing data
    task automatic back_pressure(input int n, input logic [SW-1:0] base);
        int prev_acc = -1;
        bit prev_blk = 0;
        for (int i = 0; i < n; i++) begin
            bit blk = 0;
            int k = 0;
            in_left = base + SW'(i); in_right = ~(base + SW'(i)); in_valid = 1'b1;
            while (!in_ready && k < 1200) begin blk = 1; @(negedge clk); k++; end
            check("bp_accept", in_ready, 1'b1);
            if (!in_ready) break;
            push(in_left, in_right, cyc + 1);
            if (prev_blk && blk) check("bp_accept_spacing", (cyc + 1) - prev_acc, FRAME);
            prev_acc = cyc + 1; prev_blk = blk;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin : stimulus
        int k, uf_before, l0;
        rst = 1'b1; pll_locked = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_outputs", {in_ready, i2s_bclk, i2s_lrclk, i2s_sdata, underflow}, 5'b0);
        rst = 1'b0;
        @(negedge clk);
        check("outputs_before_lock_sync", {in_ready, i2s_bclk, i2s_lrclk, i2s_sdata}, 4'b0);
        wait_ready("lock_to_ready", 6);
        check("lrclk_at_run_start", i2s_lrclk, 1'b0);
        align_on = 1;

        // directed pattern, then no write before the second load
        send_pair(16'hA5C3, 16'h8001);
        wait_loads("second_load_seen", 2);
        check("underflow_frame2_count", uf_seen, 1);

        // randomized pairs with random gaps
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 700)) @(negedge clk);
            send_pair(SW'($urandom), SW'($urandom));
        end

        back_pressure(5, 16'h1000);

        // lose lock in the right slot
        k = 0;
        while (!(pos >= 40 && pos <= 50) && k < 2 * FRAME) begin @(negedge clk); k++; end
        align_on = 0;
        pll_locked = 1'b0;
        k = 0;
        while ({in_ready, i2s_bclk, i2s_lrclk, i2s_sdata, underflow} != 5'b0 && k < 6) begin
            @(negedge clk); k++;
        end
        check("lockloss_within_3clk", (k <= 3), 1'b1);
        repeat (30) @(negedge clk);
        check("idle_outputs", {in_ready, i2s_bclk, i2s_lrclk, i2s_sdata, underflow}, 5'b0);
        q.delete();

        // relock: first frame underflows, next one carries a fresh pair
        pll_locked = 1'b1;
        wait_ready("relock_to_ready", 6);
        align_on = 1;
        l0 = loads_seen; uf_before = uf_seen;
        wait_loads("relock_first_load", l0 + 1);
        check("relock_underflow", uf_seen - uf_before, 1);
        send_pair(SW'($urandom), SW'($urandom));
        repeat (3 * FRAME + 50) @(negedge clk);

        check("scoreboard_drained", q.size(), 0);
        check("underflow_total", uf_seen, uf_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
